// File: rtl/uart_mmio_peripheral.sv
// Memory-mapped 8N1 UART on the data-memory bus: register decode, TX and RX FSMs,
// programmable baud divider, combinational read-back.
module uart_mmio_peripheral #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
   parameter logic [15:0] DEFAULT_DIV = 16'd15,
   parameter logic [15:0] DIV_MIN     = 16'd3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ADDR,
   input  logic [1:0]  WE,
   input  logic        RE,
   input  logic [31:0] WD,
   output logic [31:0] RD,
   output logic        sel,
   input  logic        uart_rx,
   output logic        uart_tx,
   output logic        irq
);

   localparam int unsigned CNT_W  = 16;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned BIT_W  = 3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_e;

   // ---------------------------------------------------------------- decode
   logic [1:0] offs;
   logic       wr_c;
   logic       tx_wr_c;
   logic       rx_pop_c;
   logic       stat_wr_c;
   logic       div_wr_c;
   logic       unused_bits;

   assign sel       = (ADDR[31:4] == BASE_ADDR[31:4]);
   assign offs      = ADDR[3:2];
   assign wr_c      = sel & (WE != 2'b00);
   assign tx_wr_c   = wr_c & (offs == 2'd0);
   assign stat_wr_c = wr_c & (offs == 2'd2);
   assign div_wr_c  = wr_c & (offs == 2'd3);
   // a load that also carries a write enable is treated as a write only
   assign rx_pop_c  = sel & RE & (WE == 2'b00) & (offs == 2'd1);
   assign unused_bits = ^{ADDR[1:0], WD[31:16]};

   // ---------------------------------------------------------------- baud divider
   logic [CNT_W-1:0] div_q, div_d;
   logic [CNT_W:0]   period_c;
   logic [CNT_W-1:0] half_c;

   assign period_c = (CNT_W+1)'(div_q) + (CNT_W+1)'(1);
   assign half_c   = period_c[CNT_W:1];

   always_comb begin
      div_d = div_q;
      if (div_wr_c) begin
         div_d = (WD[15:0] < DIV_MIN) ? DIV_MIN : WD[15:0];
      end
   end

   // ---------------------------------------------------------------- TX
   state_e            tx_state_q, tx_state_d;
   logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
   logic [BIT_W-1:0]  tx_bit_q, tx_bit_d;
   logic [BYTE_W-1:0] tx_shift_q, tx_shift_d;
   logic              tx_line_q, tx_line_d;
   logic              tx_busy_q, tx_busy_d;

   // busy falls in the same edge that returns to IDLE, so a store in that cycle is dropped
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_line_d  = tx_line_q;
      tx_busy_d  = tx_busy_q;
      unique case (tx_state_q)
         S_IDLE: begin
            if (tx_wr_c && !tx_busy_q) begin
               tx_state_d = S_START;
               tx_cnt_d   = div_q;
               tx_shift_d = WD[7:0];
               tx_bit_d   = '0;
               tx_line_d  = 1'b0;
               tx_busy_d  = 1'b1;
            end
         end
         S_START: begin
            if (tx_cnt_q == '0) begin
               tx_state_d = S_DATA;
               tx_cnt_d   = div_q;
               tx_bit_d   = '0;
               tx_line_d  = tx_shift_q[0];
               tx_shift_d = {1'b0, tx_shift_q[BYTE_W-1:1]};
            end else begin
               tx_cnt_d = tx_cnt_q - CNT_W'(1);
            end
         end
         S_DATA: begin
            if (tx_cnt_q == '0) begin
               tx_cnt_d = div_q;
               if (tx_bit_q == BIT_W'(7)) begin
                  tx_state_d = S_STOP;
                  tx_line_d  = 1'b1;
               end else begin
                  tx_bit_d   = tx_bit_q + BIT_W'(1);
                  tx_line_d  = tx_shift_q[0];
                  tx_shift_d = {1'b0, tx_shift_q[BYTE_W-1:1]};
               end
            end else begin
               tx_cnt_d = tx_cnt_q - CNT_W'(1);
            end
         end
         S_STOP: begin
            if (tx_cnt_q == '0) begin
               tx_state_d = S_IDLE;
               tx_busy_d  = 1'b0;
            end else begin
               tx_cnt_d = tx_cnt_q - CNT_W'(1);
            end
         end
         default: tx_state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- RX
   logic              rx_meta_q, rx_sync_q;
   state_e            rx_state_q, rx_state_d;
   logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
   logic [BIT_W-1:0]  rx_bit_q, rx_bit_d;
   logic [BYTE_W-1:0] rx_shift_q, rx_shift_d;
   logic              rx_done_c;
   logic              rx_ferr_c;

   // start is confirmed half a bit after the falling edge; the FSM leaves STOP at the sample
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_done_c  = 1'b0;
      rx_ferr_c  = 1'b0;
      unique case (rx_state_q)
         S_IDLE: begin
            if (!rx_sync_q) begin
               rx_state_d = S_START;
               rx_cnt_d   = half_c - CNT_W'(1);
            end
         end
         S_START: begin
            if (rx_cnt_q == '0) begin
               if (!rx_sync_q) begin
                  rx_state_d = S_DATA;
                  rx_cnt_d   = div_q;
                  rx_bit_d   = '0;
               end else begin
                  rx_state_d = S_IDLE;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - CNT_W'(1);
            end
         end
         S_DATA: begin
            if (rx_cnt_q == '0) begin
               rx_cnt_d   = div_q;
               rx_shift_d = {rx_sync_q, rx_shift_q[BYTE_W-1:1]};
               if (rx_bit_q == BIT_W'(7)) begin
                  rx_state_d = S_STOP;
               end else begin
                  rx_bit_d = rx_bit_q + BIT_W'(1);
               end
            end else begin
               rx_cnt_d = rx_cnt_q - CNT_W'(1);
            end
         end
         S_STOP: begin
            if (rx_cnt_q == '0) begin
               rx_state_d = S_IDLE;
               rx_done_c  = rx_sync_q;
               rx_ferr_c  = ~rx_sync_q;
            end else begin
               rx_cnt_d = rx_cnt_q - CNT_W'(1);
            end
         end
         default: rx_state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- RX holding register and flags
   logic [BYTE_W-1:0] rx_byte_q, rx_byte_d;
   logic              rx_valid_q, rx_valid_d;
   logic              rx_ovr_q, rx_ovr_d;
   logic              ferr_q, ferr_d;

   // clears first, then set events, so a new error beats a same-cycle W1C
   always_comb begin
      rx_byte_d  = rx_byte_q;
      rx_valid_d = rx_valid_q;
      rx_ovr_d   = rx_ovr_q;
      ferr_d     = ferr_q;
      if (stat_wr_c) begin
         if (WD[3]) ferr_d   = 1'b0;
         if (WD[2]) rx_ovr_d = 1'b0;
      end
      if (rx_pop_c) rx_valid_d = 1'b0;
      if (rx_done_c) begin
         if (!rx_valid_q || rx_pop_c) begin
            rx_byte_d  = rx_shift_q;
            rx_valid_d = 1'b1;
         end else begin
            rx_ovr_d = 1'b1;
         end
      end
      if (rx_ferr_c) ferr_d = 1'b1;
   end

   // ---------------------------------------------------------------- state registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_q      <= DEFAULT_DIV;
         tx_state_q <= S_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_line_q  <= 1'b1;
         tx_busy_q  <= 1'b0;
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_state_q <= S_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_byte_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_ovr_q   <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         div_q      <= div_d;
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_line_q  <= tx_line_d;
         tx_busy_q  <= tx_busy_d;
         rx_meta_q  <= uart_rx;
         rx_sync_q  <= rx_meta_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_byte_q  <= rx_byte_d;
         rx_valid_q <= rx_valid_d;
         rx_ovr_q   <= rx_ovr_d;
         ferr_q     <= ferr_d;
      end
   end

   // ---------------------------------------------------------------- outputs
   assign uart_tx = tx_line_q;
   assign irq     = rx_valid_q | rx_ovr_q | ferr_q;

   always_comb begin
      RD = '0;
      if (sel) begin
         unique case (offs)
            2'd1:    RD = {24'b0, rx_byte_q};
            2'd2:    RD = {28'b0, ferr_q, rx_ovr_q, rx_valid_q, tx_busy_q};
            2'd3:    RD = {16'b0, div_q};
            default: RD = '0;
         endcase
      end
   end

endmodule
